// File: rtl/interboard_receiver.sv
// Receiving end of the inter-board Request/Ack link: collects four 6-bit words
// into a 24-bit control frame and presents the decoded fields to game control.
module interboard_receiver #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request,
    input  logic [5:0] interboard_data,
    output logic       Ack,
    output logic       interboard_rst,
    output logic       interboard_en,
    output logic       interboard_move_dir,
    output logic [4:0] interboard_block_x,
    output logic [2:0] interboard_block_y,
    output logic [3:0] interboard_msg_type,
    output logic [5:0] interboard_card,
    output logic [2:0] interboard_sel_len
);

    localparam int unsigned WORD_W  = 6;
    localparam int unsigned FRAME_W = 24;
    localparam int unsigned WCNT_W  = 2;

    localparam logic [0:0] WAIT_REQ = 1'b0;
    localparam logic [0:0] ACK_HIGH = 1'b1;

    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WCNT_W-1:0] LAST_WRD = WCNT_W'(3);

    logic              req_s1_q, req_s_q;
    logic [WORD_W-1:0] data_s1_q, data_s_q;

    logic [0:0]         state_q, state_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               ack_q, ack_d;
    logic               hold_q, hold_d;
    logic               en_q, en_d;
    logic               irst_q, irst_d;
    logic               move_dir_q, move_dir_d;
    logic [4:0]         block_x_q, block_x_d;
    logic [2:0]         block_y_q, block_y_d;
    logic [3:0]         msg_type_q, msg_type_d;
    logic [5:0]         card_q, card_d;
    logic [2:0]         sel_len_q, sel_len_d;
    logic               running_c;

    // Two-flop synchronisers for the asynchronous inbound pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s1_q  <= 1'b0;
            req_s_q   <= 1'b0;
            data_s1_q <= '0;
            data_s_q  <= '0;
        end else begin
            req_s1_q  <= Request;
            req_s_q   <= req_s1_q;
            data_s1_q <= interboard_data;
            data_s_q  <= data_s1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        cnt_d      = '0;
        shift_d    = shift_q;
        ack_d      = ack_q;
        hold_d     = hold_q;
        en_d       = 1'b0;
        irst_d     = 1'b0;
        move_dir_d = move_dir_q;
        block_x_d  = block_x_q;
        block_y_d  = block_y_q;
        msg_type_d = msg_type_q;
        card_d     = card_q;
        sel_len_d  = sel_len_q;
        running_c  = (state_q == ACK_HIGH) || (word_cnt_q != '0);

        case (state_q)
            WAIT_REQ: begin
                // hold_q blocks re-capture of a Request still high after an abort
                if (!req_s_q) begin
                    hold_d = 1'b0;
                end
                if (req_s_q && !hold_q) begin
                    shift_d = {shift_q[FRAME_W-WORD_W-1:0], data_s_q};
                    state_d = ACK_HIGH;
                    ack_d   = 1'b1;
                end
            end
            ACK_HIGH: begin
                if (!req_s_q) begin
                    state_d = WAIT_REQ;
                    ack_d   = 1'b0;
                    if (word_cnt_q == LAST_WRD) begin
                        word_cnt_d = '0;
                        if (shift_q[23]) begin
                            irst_d = 1'b1;
                        end else begin
                            en_d       = 1'b1;
                            msg_type_d = shift_q[21:18];
                            move_dir_d = shift_q[17];
                            block_x_d  = shift_q[16:12];
                            block_y_d  = shift_q[11:9];
                            card_d     = shift_q[8:3];
                            sel_len_d  = shift_q[2:0];
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_REQ;
                ack_d   = 1'b0;
            end
        endcase

        // Stall timer: any state change counts as progress and clears it
        if ((state_d == state_q) && running_c) begin
            if (cnt_q == TO_LAST) begin
                state_d    = WAIT_REQ;
                ack_d      = 1'b0;
                word_cnt_d = '0;
                shift_d    = '0;
                hold_d     = req_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_REQ;
            word_cnt_q <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            ack_q      <= 1'b0;
            hold_q     <= 1'b0;
            en_q       <= 1'b0;
            irst_q     <= 1'b0;
            move_dir_q <= 1'b0;
            block_x_q  <= '0;
            block_y_q  <= '0;
            msg_type_q <= '0;
            card_q     <= '0;
            sel_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ack_q      <= ack_d;
            hold_q     <= hold_d;
            en_q       <= en_d;
            irst_q     <= irst_d;
            move_dir_q <= move_dir_d;
            block_x_q  <= block_x_d;
            block_y_q  <= block_y_d;
            msg_type_q <= msg_type_d;
            card_q     <= card_d;
            sel_len_q  <= sel_len_d;
        end
    end

    assign Ack                 = ack_q;
    assign interboard_rst      = irst_q;
    assign interboard_en       = en_q;
    assign interboard_move_dir = move_dir_q;
    assign interboard_block_x  = block_x_q;
    assign interboard_block_y  = block_y_q;
    assign interboard_msg_type = msg_type_q;
    assign interboard_card     = card_q;
    assign interboard_sel_len  = sel_len_q;

endmodule

// File: tb/tb_interboard_receiver.sv
// Self-checking bench for interboard_receiver: table frames, random frames
// against a field-extraction model, and timeout / reset corner sequences.
module tb_interboard_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       Request;
    logic [5:0] interboard_data;
    logic       Ack;
    logic       interboard_rst;
    logic       interboard_en;
    logic       interboard_move_dir;
    logic [4:0] interboard_block_x;
    logic [2:0] interboard_block_y;
    logic [3:0] interboard_msg_type;
    logic [5:0] interboard_card;
    logic [2:0] interboard_sel_len;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int rst_cnt  = 0;
    int exp_en   = 0;
    int exp_rst  = 0;
    logic en_prev = 1'b0;

    int m_msg, m_md, m_bx, m_by, m_card, m_sl;

    typedef struct {
        logic [23:0] frame;
        logic [3:0]  msg;
        logic        md;
        logic [4:0]  bx;
        logic [2:0]  by;
        logic [5:0]  card;
        logic [2:0]  sl;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    interboard_receiver #(.TIMEOUT_CYCLES(50), .CNT_W(20)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .Request             (Request),
        .interboard_data     (interboard_data),
        .Ack                 (Ack),
        .interboard_rst      (interboard_rst),
        .interboard_en       (interboard_en),
        .interboard_move_dir (interboard_move_dir),
        .interboard_block_x  (interboard_block_x),
        .interboard_block_y  (interboard_block_y),
        .interboard_msg_type (interboard_msg_type),
        .interboard_card     (interboard_card),
        .interboard_sel_len  (interboard_sel_len)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (interboard_en) en_cnt++;
        if (interboard_rst) rst_cnt++;
        if (interboard_en) begin
            check("en_single_cycle", int'(en_prev), 0);
            check("en_rst_exclusive", int'(interboard_rst), 0);
        end
        en_prev = interboard_en;
    end

    // Reference: fields are plain bit ranges of the 24-bit frame
    task automatic model_frame(input logic [23:0] f);
        int v;
        v = int'(f);
        if (((v >> 23) & 1) == 1) begin
            exp_rst++;
        end else begin
            exp_en++;
            m_msg  = (v >> 18) & 15;
            m_md   = (v >> 17) & 1;
            m_bx   = (v >> 12) & 31;
            m_by   = (v >> 9) & 7;
            m_card = (v >> 3) & 63;
            m_sl   = v & 7;
        end
    endtask

    task automatic check_fields(input string tag);
        check({tag, ".msg_type"}, int'(interboard_msg_type), m_msg);
        check({tag, ".move_dir"}, int'(interboard_move_dir), m_md);
        check({tag, ".block_x"},  int'(interboard_block_x),  m_bx);
        check({tag, ".block_y"},  int'(interboard_block_y),  m_by);
        check({tag, ".card"},     int'(interboard_card),     m_card);
        check({tag, ".sel_len"},  int'(interboard_sel_len),  m_sl);
    endtask

    task automatic check_all(input string tag);
        repeat (2) @(negedge clk);
        check({tag, ".en_count"},  en_cnt,  exp_en);
        check({tag, ".rst_count"}, rst_cnt, exp_rst);
        check_fields(tag);
    endtask

    task automatic wait_ack(input logic val, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Ack == val) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: Ack stuck at %0b, expected %0b", tag, Ack, val);
        end
    endtask

    // Data is scrambled once Ack is seen, so the captured word must be the early one
    task automatic send_word(input logic [5:0] w);
        @(negedge clk);
        interboard_data = w;
        Request = 1'b1;
        wait_ack(1'b1, "ack_rise");
        interboard_data = 6'($urandom);
        Request = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic send_frame(input logic [23:0] f);
        for (int i = 0; i < 4; i++) begin
            send_word(6'(f >> (18 - 6 * i)));
        end
        model_frame(f);
    endtask

    initial begin
        logic [23:0] f;
        rst = 1'b1;
        Request = 1'b0;
        interboard_data = '0;
        m_msg = 0; m_md = 0; m_bx = 0; m_by = 0; m_card = 0; m_sl = 0;

        vecs[0] = '{24'h16AF1D, 4'h5, 1'b1, 5'h0A, 3'h7, 6'h23, 3'h5};
        vecs[1] = '{24'h3FFFFF, 4'hF, 1'b1, 5'h1F, 3'h7, 6'h3F, 3'h7};
        vecs[2] = '{24'h0C1234, 4'h3, 1'b0, 5'h01, 3'h1, 6'h06, 3'h4};
        vecs[3] = '{24'h000000, 4'h0, 1'b0, 5'h00, 3'h0, 6'h00, 3'h0};

        repeat (3) @(negedge clk);
        check("reset.Ack", int'(Ack), 0);
        check("reset.en", int'(interboard_en), 0);
        check("reset.rst_pulse", int'(interboard_rst), 0);
        check_fields("reset");
        rst = 1'b0;

        // Table frames sent back-to-back with no idle
        foreach (vecs[i]) begin
            send_frame(vecs[i].frame);
            repeat (2) @(negedge clk);
            check("table.en_count", en_cnt, exp_en);
            check("table.msg_type", int'(interboard_msg_type), int'(vecs[i].msg));
            check("table.move_dir", int'(interboard_move_dir), int'(vecs[i].md));
            check("table.block_x", int'(interboard_block_x), int'(vecs[i].bx));
            check("table.block_y", int'(interboard_block_y), int'(vecs[i].by));
            check("table.card", int'(interboard_card), int'(vecs[i].card));
            check("table.sel_len", int'(interboard_sel_len), int'(vecs[i].sl));
        end
        check("table.Ack_end", int'(Ack), 0);

        send_frame(24'h16AF1D);
        check_all("before_rstframe");
        send_frame(24'h800000);
        check_all("rst_frame");

        // Stall in WAIT_REQ after two words
        send_word(6'h11);
        send_word(6'h22);
        repeat (70) @(negedge clk);
        check("stall_wait.Ack", int'(Ack), 0);
        check("stall_wait.en_count", en_cnt, exp_en);
        send_frame(24'h0C1234);
        check_all("after_stall_wait");

        // Request held high on word 0: abort, then ignore until Request drops
        @(negedge clk);
        interboard_data = 6'h15;
        Request = 1'b1;
        repeat (10) @(negedge clk);
        check("stall_ack.Ack_high", int'(Ack), 1);
        repeat (60) @(negedge clk);
        check("stall_ack.Ack_abort", int'(Ack), 0);
        repeat (20) @(negedge clk);
        check("stall_ack.Ack_held_low", int'(Ack), 0);
        Request = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(24'h16AF1D);
        check_all("after_stall_ack");

        // Async reset during ACK_HIGH of word 2
        send_frame(24'h3FFFFF);
        check_all("before_async");
        send_word(6'h05);
        send_word(6'h2A);
        @(negedge clk);
        interboard_data = 6'h3C;
        Request = 1'b1;
        wait_ack(1'b1, "async.ack_rise");
        #2 rst = 1'b1;
        #1;
        m_msg = 0; m_md = 0; m_bx = 0; m_by = 0; m_card = 0; m_sl = 0;
        check("async.Ack", int'(Ack), 0);
        check("async.en", int'(interboard_en), 0);
        check_fields("async");
        Request = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_frame(24'h16AF1D);
        check_all("after_async");

        // Random frames, roughly one in four a reset frame
        for (int i = 0; i < 40; i++) begin
            f = 24'($urandom);
            f[23] = ($urandom_range(3) == 0);
            send_frame(f);
            if (($urandom_range(1)) == 1) repeat ($urandom_range(5)) @(negedge clk);
        end
        check_all("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
